mpu_store: RTL and testbench
============================

# mpu_store

Matrix store engine for the MPU: on command, reads one matrix register (elements plus m/n dimensions) from `mpu_register_file` and streams its elements out one per handshake, row-major, toward memory or the testbench BFM. It is the read-side counterpart of `mpu_load` and sits between the register file's store port and the memory interface.

## Interface
Parameters (defaults from `global_defs`):
- `FP`, 32, element width in bits (IEEE-754 single).
- `M`, 4, maximum rows.
- `N`, 4, maximum columns.
- `MBITS`, `$clog2(M)`, row index width; size fields are `[MBITS:0]`.
- `NBITS`, `$clog2(N)`, column index width; size fields are `[NBITS:0]`.
- `MATRIX_REG_SIZE`, 3, register-file address width.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  start pulse, sampled only in IDLE.
- `store_addr`  in  MATRIX_REG_SIZE  register to read.
- `reg_store_addr`  out  MATRIX_REG_SIZE  address to the register file.
- `reg_matrix_in`  in  FP×M×N  register file `matrix_out`, indexed `[row][col]`.
- `reg_m_in`, `reg_n_in`  in  MBITS+1 / NBITS+1  stored dimensions.
- `element_out`  out  FP  streamed element.
- `element_valid`  out  1  `element_out` valid.
- `element_ready`  in  1  sink accepts on `valid && ready`.
- `element_last`  out  1  marks the final element.
- `matrix_m_size`, `matrix_n_size`  out  MBITS+1 / NBITS+1  dimensions being streamed.
- `busy`  out  1  not IDLE.
- `ack`  out  1  one-cycle pulse on completion, success or error.
- `error`  out  1  one-cycle pulse, coincident with `ack`, on bad dimensions.

## Operation
- States: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - `en=1` latches `store_addr` into `reg_store_addr` and moves to FETCH.
  - `en` is ignored in every other state; there is no queueing.
- FETCH (1 cycle):
  - Copies `reg_matrix_in`, `reg_m_in` and `reg_n_in` into a local buffer.
  - Zeroes the row/column counters.
  - If m=0, n=0, m>M or n>N, sets the error flag and goes to DONE.
  - Otherwise goes to STREAM.
- STREAM:
  - `element_valid=1`; `element_out` = buffer[row][col].
  - On handshake, col increments. When col=n-1, col wraps to 0 and row increments.
  - `element_last=1` while row=m-1 and col=n-1.
  - Handshake on the last element goes to DONE.
  - While ready is low, `element_out`, `element_last` and the counters hold stable.
- DONE (1 cycle): `ack=1`, `error` = error flag, then IDLE; flag clears.
- The local buffer isolates the stream from register-file writes made after FETCH.
- Counter compares use the full `[MBITS:0]`/`[NBITS:0]` widths so m=M and n=N do not overflow.
- Reset values (`rst=0` at a clock edge): state IDLE; all outputs 0, including `reg_store_addr`, `matrix_m_size` and `matrix_n_size`; counters 0; buffer contents don't-care.
- Reset mid-stream aborts with no `ack`; the next cycle shows `valid=0`.

## Timing
- Cycle 0: `en` sampled. Cycle 1: FETCH, `reg_store_addr` stable. Cycle 2: first `element_valid`.
- The register file is read combinationally off `reg_store_addr` during FETCH.
- With ready held high, element k is accepted in cycle 2+k. The last element goes at cycle 1+m·n and `ack` at cycle 2+m·n.
- `busy` is high from cycle 1 through the `ack` cycle inclusive.
- Error path: `ack` and `error` in cycle 2; no `element_valid` ever.
- `matrix_m_size`/`matrix_n_size` are valid from cycle 2 until the next FETCH.
- `en` in the `ack` cycle is ignored. `en` in the first IDLE cycle after `ack` starts a new store.

## Configuration
- `MPU_STORE_TRANSPOSE_EN`
  - Defined: streams column-major, row as the fast index, so the sink receives the transpose. `matrix_m_size` reports n and `matrix_n_size` reports m. `element_last` is on buffer[m-1][n-1]. Latency is unchanged.
  - Undefined: row-major streaming as described above.

## Test plan
- Load a 2×2 into reg 0 as [1.0, 50.33; -2.5, 0.125], then store reg 0 with ready high. Expect 3f800000, 424951ec, c0200000, 3e000000 in cycles 2–5, last in cycle 5, ack in cycle 6, sizes 2/2, error=0.
- Same store with ready low in cycles 3–4. Expect 424951ec held stable for 3 cycles, no skipped or duplicated element, ack in cycle 8.
- Store a register holding m=0 (or m=M+1). Expect ack=error=1 in cycle 2, valid never asserted, busy low in cycle 3.
- Pulse `en` with store_addr=1 during STREAM of reg 0. Expect it to be ignored: reg 0's stream completes intact and only one ack.
- Assert `rst=0` after 2 of 4 elements. Expect all outputs 0 next cycle and no ack; a fresh store then completes normally.
- With `MPU_STORE_TRANSPOSE_EN` defined, store a 2×3 [1..6]. Expect 1,4,2,5,3,6, sizes 3/2, last on 6.

Source files
------------

// File: rtl/mpu_store.sv
// Matrix store engine: fetches one register-file matrix into a local buffer and streams
// its elements over a valid/ready port. Define MPU_STORE_TRANSPOSE_EN for column-major output.
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [MATRIX_REG_SIZE-1:0]       store_addr,
  output logic [MATRIX_REG_SIZE-1:0]       reg_store_addr,
  input  logic [M-1:0][N-1:0][FP-1:0]      reg_matrix_in,
  input  logic [MBITS:0]                   reg_m_in,
  input  logic [NBITS:0]                   reg_n_in,
  output logic [FP-1:0]                    element_out,
  output logic                             element_valid,
  input  logic                             element_ready,
  output logic                             element_last,
  output logic [MBITS:0]                   matrix_m_size,
  output logic [NBITS:0]                   matrix_n_size,
  output logic                             busy,
  output logic                             ack,
  output logic                             error,
  output logic [1:0]                       dbg_state
);

  // Handshake: an element transfers on a rising clk edge where element_valid && element_ready;
  // while valid is high and ready is low, element_out/element_last hold and valid stays high.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  state_t                          state_q, state_d;
  logic [MATRIX_REG_SIZE-1:0]      addr_q, addr_d;
  logic [M-1:0][N-1:0][FP-1:0]     buf_q, buf_d;
  logic [MBITS:0]                  m_q, m_d, row_q, row_d, msz_q, msz_d;
  logic [NBITS:0]                  n_q, n_d, col_q, col_d, nsz_q, nsz_d;
  logic                            err_q, err_d;

  logic [MBITS:0] m_last;
  logic [NBITS:0] n_last;
  logic           row_end, col_end, last_elem, bad_dims;

  assign m_last    = m_q - (MBITS+1)'(1);
  assign n_last    = n_q - (NBITS+1)'(1);
  assign row_end   = (row_q == m_last);
  assign col_end   = (col_q == n_last);
  assign last_elem = row_end && col_end;
  assign bad_dims  = (reg_m_in == '0) || (reg_n_in == '0) || (reg_m_in > M_MAX) || (reg_n_in > N_MAX);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    msz_d   = msz_q;
    nsz_d   = nsz_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          addr_d  = store_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        buf_d = reg_matrix_in;
        m_d   = reg_m_in;
        n_d   = reg_n_in;
        row_d = '0;
        col_d = '0;
`ifdef MPU_STORE_TRANSPOSE_EN
        msz_d = (MBITS+1)'(reg_n_in);
        nsz_d = (NBITS+1)'(reg_m_in);
`else
        msz_d = reg_m_in;
        nsz_d = reg_n_in;
`endif
        if (bad_dims) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (element_ready) begin
          if (last_elem) begin
            state_d = S_DONE;
          end
`ifdef MPU_STORE_TRANSPOSE_EN
          else if (row_end) begin
            row_d = '0;
            col_d = col_q + (NBITS+1)'(1);
          end else begin
            row_d = row_q + (MBITS+1)'(1);
          end
`else
          else if (col_end) begin
            col_d = '0;
            row_d = row_q + (MBITS+1)'(1);
          end else begin
            col_d = col_q + (NBITS+1)'(1);
          end
`endif
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      msz_q   <= '0;
      nsz_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      msz_q   <= msz_d;
      nsz_q   <= nsz_d;
      err_q   <= err_d;
    end
  end

  // Element data is forced to zero outside STREAM so reset/idle outputs read as 0.
  assign element_valid  = (state_q == S_STREAM);
  assign element_out    = element_valid ? buf_q[row_q[MBITS-1:0]][col_q[NBITS-1:0]] : '0;
  assign element_last   = element_valid && last_elem;
  assign reg_store_addr = addr_q;
  assign matrix_m_size  = msz_q;
  assign matrix_n_size  = nsz_q;
  assign busy           = (state_q != S_IDLE);
  assign ack            = (state_q == S_DONE);
  assign error          = (state_q == S_DONE) && err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mpu_store.sv
// Testbench for mpu_store: register-file BFM, per-cycle stream monitor against an expected queue,
// directed cases with literal pins and randomized stores with random back-pressure.
module tb_mpu_store;
  localparam int FP = 32, M = 4, N = 4, MBITS = 2, NBITS = 2, RS = 3;

  logic                        clk, rst, en, element_ready;
  logic [RS-1:0]               store_addr, reg_store_addr;
  logic [M-1:0][N-1:0][FP-1:0] reg_matrix_in;
  logic [MBITS:0]              reg_m_in, matrix_m_size;
  logic [NBITS:0]              reg_n_in, matrix_n_size;
  logic [FP-1:0]               element_out;
  logic                        element_valid, element_last, busy, ack, error;
  logic [1:0]                  dbg_state;

  mpu_store #(.FP(FP), .M(M), .N(N), .MBITS(MBITS), .NBITS(NBITS), .MATRIX_REG_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .en(en), .store_addr(store_addr), .reg_store_addr(reg_store_addr),
    .reg_matrix_in(reg_matrix_in), .reg_m_in(reg_m_in), .reg_n_in(reg_n_in),
    .element_out(element_out), .element_valid(element_valid), .element_ready(element_ready),
    .element_last(element_last), .matrix_m_size(matrix_m_size), .matrix_n_size(matrix_n_size),
    .busy(busy), .ack(ack), .error(error), .dbg_state(dbg_state));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file model, read combinationally off reg_store_addr
  logic [M-1:0][N-1:0][FP-1:0] mats [8];
  logic [MBITS:0]              ms [8];
  logic [NBITS:0]              ns [8];
  always_comb begin
    reg_matrix_in = mats[reg_store_addr];
    reg_m_in      = ms[reg_store_addr];
    reg_n_in      = ns[reg_store_addr];
  end

  // scoreboard: {last, data}
  logic [FP:0]    exp_q [$];
  logic [FP-1:0]  got_q [$];
  int             cyc_q [$];
  int             checks = 0, errors = 0, rel_cyc = 0;
  int             exp_msz = 0, exp_nsz = 0;
  logic           prev_stall = 1'b0;
  logic [FP-1:0]  prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else if (element_valid) begin
      chk("m_size", 64'(matrix_m_size), 64'(exp_msz));
      chk("n_size", 64'(matrix_n_size), 64'(exp_nsz));
      if (prev_stall) chk("hold_data", element_out, prev_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got %0h expected no element", element_out);
      end else begin
        chk("element", element_out, exp_q[0][FP-1:0]);
        chk("last", element_last, exp_q[0][FP]);
        if (element_ready) begin
          void'(exp_q.pop_front());
          got_q.push_back(element_out);
          cyc_q.push_back(rel_cyc);
        end
      end
      prev_stall = !element_ready;
      prev_data  = element_out;
    end else begin
      if (prev_stall) chk("hold_valid", element_valid, 1);
      prev_stall = 1'b0;
    end
  end

  function automatic logic pick_ready(input int mode, input int r);
    if (mode == 1) return !(r == 3 || r == 4);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  // Expected stream order and sizes from the matrix rules (row-major or transpose).
  task automatic load_expect(input int a);
    int m, n, k;
    m = int'(ms[a]);
    n = int'(ns[a]);
    k = 0;
`ifdef MPU_STORE_TRANSPOSE_EN
    exp_msz = n;
    exp_nsz = m;
    for (int c = 0; c < n; c++)
      for (int r = 0; r < m; r++) begin
        k++;
        exp_q.push_back({(k == m * n), mats[a][r][c]});
      end
`else
    exp_msz = m;
    exp_nsz = n;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        k++;
        exp_q.push_back({(k == m * n), mats[a][r][c]});
      end
`endif
  endtask

  // driver: called right after a posedge; returns ack cycle relative to the en cycle
  task automatic run_store(input int a, input int rmode, input int poke, output int ack_at);
    int m, n, mn, hs, exp_ack, r;
    bit bad, done;
    chk("idle_busy", busy, 0);
    m   = int'(ms[a]);
    n   = int'(ns[a]);
    bad = (m == 0) || (n == 0) || (m > M) || (n > N);
    mn  = m * n;
    got_q.delete();
    cyc_q.delete();
    if (!bad) load_expect(a);
    exp_ack = bad ? 2 : -1;
    hs = 0; ack_at = -1; r = 0; done = 0;
    rel_cyc = 0;
    en = 1'b1;
    store_addr = RS'(a);
    element_ready = pick_ready(rmode, 0);
    while (!done && r < 300) begin
      @(negedge clk);
      if (r >= 1) begin
        chk("busy", busy, 1);
        chk("reg_store_addr", reg_store_addr, 64'(a));
      end
      if (ack) begin
        ack_at = r;
        done = 1;
        chk("error", error, bad);
      end else begin
        @(posedge clk);
        #1;
        r++;
        rel_cyc = r;
        en = (r == poke);
        store_addr = (r == poke) ? RS'(1) : RS'(a);
        element_ready = pick_ready(rmode, r);
        if (r == 2 && rmode == 2)
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) mats[a][i][j] = $urandom;
        if (!bad && r >= 2 && element_ready && hs < mn) begin
          hs++;
          if (hs == mn) exp_ack = r + 1;
        end
      end
    end
    chk("ack_cycle", 64'(ack_at), 64'(exp_ack));
    chk("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {element_out, element_valid, element_last, matrix_m_size, matrix_n_size,
               busy, ack, error, reg_store_addr}, 0);
  endtask

  logic [FP-1:0] lit [4];
  int ack_at;

  initial begin
    for (int a = 0; a < 8; a++) begin
      mats[a] = '0;
      ms[a] = 3'd2;
      ns[a] = 3'd2;
    end
    mats[0][0][0] = 32'h3f800000; mats[0][0][1] = 32'h424951ec;
    mats[0][1][0] = 32'hc0200000; mats[0][1][1] = 32'h3e000000;
    ms[2] = 3'd0;
    ms[3] = 3'(M + 1);
    ms[4] = 3'd2; ns[4] = 3'd3;
    for (int k = 0; k < 6; k++) mats[4][k / 3][k % 3] = 32'(k + 1);
    rst = 1'b0; en = 1'b0; store_addr = '0; element_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 2x2 with ready high
    run_store(0, 0, -1, ack_at);
    chk("t1_ack", 64'(ack_at), 6);
`ifdef MPU_STORE_TRANSPOSE_EN
    lit = '{32'h3f800000, 32'hc0200000, 32'h424951ec, 32'h3e000000};
`else
    lit = '{32'h3f800000, 32'h424951ec, 32'hc0200000, 32'h3e000000};
`endif
    for (int k = 0; k < 4; k++) begin
      chk("t1_elem", (k < got_q.size()) ? got_q[k] : 32'hdeadbeef, lit[k]);
      chk("t1_cyc", (k < cyc_q.size()) ? 64'(cyc_q[k]) : 64'hffff, 64'(2 + k));
    end

    // stall in cycles 3-4
    run_store(0, 1, -1, ack_at);
    chk("t2_ack", 64'(ack_at), 8);
    chk("t2_cnt", 64'(got_q.size()), 4);
    chk("t2_cyc1", (cyc_q.size() > 1) ? 64'(cyc_q[1]) : 64'hffff, 5);

    // bad dimensions
    run_store(2, 0, -1, ack_at);
    chk("t3_ack_m0", 64'(ack_at), 2);
    chk("t3_busy_low", busy, 0);
    run_store(3, 0, -1, ack_at);
    chk("t3_ack_mbig", 64'(ack_at), 2);

    // en during STREAM is ignored
    run_store(0, 0, 3, ack_at);
    chk("t4_ack", 64'(ack_at), 6);
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_ack", ack, 0);
      chk("t4_no_busy", busy, 0);
    end
    @(posedge clk);
    #1;

    // reset after 2 of 4 elements
    got_q.delete();
    load_expect(0);
    en = 1'b1; store_addr = '0; element_ready = 1'b1; rel_cyc = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      rel_cyc = c;
      en = 1'b0;
      if (c == 4) begin
        rst = 1'b0;
        element_ready = 1'b0;
        chk("t5_two_sent", 64'(got_q.size()), 2);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all_zero("t5_after_reset");
    exp_q.delete();
    @(negedge clk);
    chk("t5_no_ack", ack, 0);
    @(posedge clk);
    #1;
    run_store(0, 0, -1, ack_at);
    chk("t5_fresh_ack", 64'(ack_at), 6);

    // 2x3 of 1..6
    run_store(4, 0, -1, ack_at);
    chk("t6_ack", 64'(ack_at), 8);
`ifdef MPU_STORE_TRANSPOSE_EN
    for (int k = 0; k < 6; k++)
      chk("t6_elem", (k < got_q.size()) ? got_q[k] : 32'hdeadbeef, 32'((k % 2) * 3 + k / 2 + 1));
`else
    for (int k = 0; k < 6; k++)
      chk("t6_elem", (k < got_q.size()) ? got_q[k] : 32'hdeadbeef, 32'(k + 1));
`endif

    // randomized stores
    for (int it = 0; it < 30; it++) begin
      int a;
      a = $urandom_range(0, 7);
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) mats[a][i][j] = $urandom;
      ms[a] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, M + 1)) : 3'($urandom_range(1, M));
      ns[a] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, N + 1)) : 3'($urandom_range(1, N));
      run_store(a, ($urandom_range(0, 1) == 0) ? 0 : 2, -1, ack_at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end
endmodule
